// File: rtl/stall_mem_resp_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stall_mem_resp_if: pipeline memory-stage request/response bundle     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface stall_mem_resp_if;
  logic        enable;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        done;
  logic        stall;
  logic        err;

  modport master (
    output enable, wr, addr, data_in,
    input  data_out, done, stall, err
  );

  modport slave (
    input  enable, wr, addr, data_in,
    output data_out, done, stall, err
  );
endinterface
`default_nettype wire

// File: rtl/stall_mem_resp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stall_mem_resp: multi-cycle data-memory responder with stall/done    |
// | Optional misalignment flag: `define MEM_ALIGN_CHECK_EN               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module stall_mem_resp #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst,
  stall_mem_resp_if.slave  bus
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] LAT_INIT = 4'(LATENCY);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [15:0]         wdata_q, wdata_d;
  logic                mis_q, mis_d;
  logic [15:0]         dout_q, dout_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                mem_we;
  logic                mis_req;
  logic [15:0]         mem [DEPTH];

`ifdef MEM_ALIGN_CHECK_EN
  assign mis_req = bus.addr[0];
`else
  assign mis_req = 1'b0;
`endif

  // High address bits alias by design; addr[0] only matters with the check enabled.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr[15:ADDR_W+1], bus.addr[0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    mis_d   = mis_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    mem_we  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.enable) begin
          state_d = ST_BUSY;
          cnt_d   = LAT_INIT;
          wr_d    = bus.wr;
          idx_d   = bus.addr[ADDR_W:1];
          wdata_d = bus.data_in;
          mis_d   = mis_req;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          if (mis_q) begin
            err_d = 1'b1;
          end else if (wr_q) begin
            mem_we = 1'b1;
          end else begin
            dout_d = mem[idx_q];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 16'h0000;
      mis_q   <= 1'b0;
      dout_q  <= 16'h0000;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      mis_q   <= mis_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Array has no reset; a reset mid-access forces IDLE so mem_we never fires.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign bus.stall    = (state_q == ST_BUSY);
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.data_out = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_stall_mem_resp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_stall_mem_resp: scoreboard bench for stall_mem_resp               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_stall_mem_resp;

  localparam int LATENCY = 4;

  typedef struct {
    logic [15:0] d;
    logic        e;
  } exp_t;

  logic clk;
  logic rst;
  stall_mem_resp_if mif ();

  stall_mem_resp #(.ADDR_W(8), .LATENCY(LATENCY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        sb[$];
  logic [15:0] model [0:255];
  logic [15:0] last_dout = 16'h0000;

  // Drives a request and records what the responder must return for it.
  task automatic send(input logic w, input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    int   idx;
    idx = int'(a[8:1]);
    mif.enable = 1'b1; mif.wr = w; mif.addr = a; mif.data_in = d;
    e.d = last_dout;
    e.e = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    if (a[0]) e.e = 1'b1;
`endif
    if (!e.e) begin
      if (w) model[idx] = d;
      else begin
        last_dout = model[idx];
        e.d = last_dout;
      end
    end
    sb.push_back(e);
  endtask

  task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d,
                       input bit wiggle, output logic [15:0] od, output logic oe,
                       output int st, output int lat, output bit to);
    @(negedge clk);
    send(w, a, d);
    to = 1'b1; st = 0; lat = 0; od = 16'hxxxx; oe = 1'bx;
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      if (mif.stall) st++;
      if (mif.done) begin
        od = mif.data_out; oe = mif.err; lat = t; to = 1'b0;
        break;
      end
      if (wiggle) begin
        mif.enable = 1'b1; mif.wr = 1'b1; mif.addr = 16'h0020; mif.data_in = 16'h1234;
      end else begin
        mif.enable = 1'b0;
      end
    end
    mif.enable = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    mif.enable = 1'b0; mif.wr = 1'b0; mif.addr = 16'h0000; mif.data_in = 16'h0000;
    repeat (3) @(negedge clk);
    n_checks++;
    if (mif.data_out !== 16'h0000 || mif.done !== 1'b0 || mif.stall !== 1'b0 || mif.err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: data_out=%h done=%b stall=%b err=%b, required 0000/0/0/0",
               mif.data_out, mif.done, mif.stall, mif.err);
    end
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (mif.data_out !== 16'h0000 || mif.done !== 1'b0 || mif.stall !== 1'b0 || mif.err !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: data_out=%h done=%b stall=%b err=%b, required 0000/0/0/0",
                 i, mif.data_out, mif.done, mif.stall, mif.err);
      end
    end
    last_dout = 16'h0000;
  endtask

  task automatic test_write_read();
    logic [15:0] od; logic oe; int st, lat; bit to; exp_t e;
    for (int k = 0; k < 2; k++) begin
      issue(k == 0 ? 1'b0 : 1'b0, 16'h0010, 16'h0000, 1'b0, od, oe, st, lat, to);
    end
    sb.delete();
    issue(1'b1, 16'h0010, 16'hBEEF, 1'b0, od, oe, st, lat, to);
    e = sb.pop_front();
    n_checks++;
    if (to || st != LATENCY || lat != LATENCY + 1) begin
      n_fail++;
      $display("FAIL wr_timing: timeout=%0d stall_cycles=%0d done_at=%0d, required 0/%0d/%0d",
               to, st, lat, LATENCY, LATENCY + 1);
    end
    n_checks++;
    if (od !== e.d || oe !== e.e) begin
      n_fail++;
      $display("FAIL wr_resp: data_out=%h err=%b, required %h/%b", od, oe, e.d, e.e);
    end
    @(negedge clk);
    n_checks++;
    if (mif.done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse_width: done=%b, required 0", mif.done);
    end
    issue(1'b0, 16'h0010, 16'h0000, 1'b0, od, oe, st, lat, to);
    e = sb.pop_front();
    n_checks++;
    if (to || st != LATENCY || lat != LATENCY + 1 || od !== e.d || e.d !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL rd_after_wr: timeout=%0d stall=%0d done_at=%0d data_out=%h, required 0/%0d/%0d/%h",
               to, st, lat, od, LATENCY, LATENCY + 1, e.d);
    end
    @(negedge clk);
    n_checks++;
    if (mif.data_out !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL data_out_hold: data_out=%h, required beef", mif.data_out);
    end
  endtask

  task automatic test_stall_ignored();
    logic [15:0] od; logic oe; int st, lat; bit to; exp_t e;
    issue(1'b1, 16'h0020, 16'h2020, 1'b0, od, oe, st, lat, to);
    void'(sb.pop_front());
    issue(1'b1, 16'h0010, 16'h1010, 1'b1, od, oe, st, lat, to);
    e = sb.pop_front();
    n_checks++;
    if (to || st != LATENCY || od !== e.d) begin
      n_fail++;
      $display("FAIL stalled_write: timeout=%0d stall=%0d data_out=%h, required 0/%0d/%h", to, st, od, LATENCY, e.d);
    end
    issue(1'b0, 16'h0010, 16'h0000, 1'b0, od, oe, st, lat, to);
    e = sb.pop_front();
    n_checks++;
    if (to || od !== e.d) begin
      n_fail++;
      $display("FAIL stalled_rd_0010: timeout=%0d data_out=%h, required %h", to, od, e.d);
    end
    issue(1'b0, 16'h0020, 16'h0000, 1'b0, od, oe, st, lat, to);
    e = sb.pop_front();
    n_checks++;
    if (to || od !== e.d) begin
      n_fail++;
      $display("FAIL stalled_rd_0020: timeout=%0d data_out=%h, required %h", to, od, e.d);
    end
  endtask

  task automatic test_back_to_back();
    int t_first, t_second, stall_cnt, ndone;
    exp_t e;
    t_first = -1; t_second = -1; stall_cnt = 0; ndone = 0;
    @(negedge clk);
    send(1'b1, 16'h0050, 16'h5A5A);
    for (int t = 1; t <= 40 && ndone < 2; t++) begin
      @(negedge clk);
      mif.enable = 1'b0;
      if (ndone == 1 && mif.stall) stall_cnt++;
      if (mif.done) begin
        ndone++;
        e = sb.pop_front();
        n_checks++;
        if (mif.data_out !== e.d || mif.err !== e.e) begin
          n_fail++;
          $display("FAIL b2b_resp%0d: data_out=%h err=%b, required %h/%b", ndone, mif.data_out, mif.err, e.d, e.e);
        end
        if (ndone == 1) begin
          t_first = t;
          send(1'b0, 16'h0050, 16'h0000);
        end else begin
          t_second = t;
        end
      end
    end
    mif.enable = 1'b0;
    n_checks++;
    if (ndone != 2 || t_second - t_first != LATENCY + 1 || stall_cnt != LATENCY) begin
      n_fail++;
      $display("FAIL b2b_timing: dones=%0d spacing=%0d stall_cycles=%0d, required 2/%0d/%0d",
               ndone, t_second - t_first, stall_cnt, LATENCY + 1, LATENCY);
    end
  endtask

  task automatic test_reset_abort();
    logic [15:0] od; logic oe; int st, lat; bit to; exp_t e; int seen;
    issue(1'b1, 16'h0030, 16'h1111, 1'b0, od, oe, st, lat, to);
    void'(sb.pop_front());
    @(negedge clk);
    mif.enable = 1'b1; mif.wr = 1'b1; mif.addr = 16'h0030; mif.data_in = 16'hAAAA;
    @(negedge clk);
    mif.enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (mif.stall !== 1'b0 || mif.done !== 1'b0 || mif.data_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL abort_async: stall=%b done=%b data_out=%h, required 0/0/0000", mif.stall, mif.done, mif.data_out);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    last_dout = 16'h0000;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mif.done || mif.stall) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL abort_no_done: busy/done cycles=%0d, required 0", seen);
    end
    issue(1'b0, 16'h0030, 16'h0000, 1'b0, od, oe, st, lat, to);
    e = sb.pop_front();
    n_checks++;
    if (to || od !== e.d || e.d !== 16'h1111) begin
      n_fail++;
      $display("FAIL abort_rd: timeout=%0d data_out=%h, required %h", to, od, e.d);
    end
  endtask

  task automatic test_misalign();
    logic [15:0] od; logic oe; int st, lat; bit to; exp_t e;
    issue(1'b1, 16'h0040, 16'h4444, 1'b0, od, oe, st, lat, to);
    void'(sb.pop_front());
    issue(1'b1, 16'h0041, 16'h9999, 1'b0, od, oe, st, lat, to);
    e = sb.pop_front();
    n_checks++;
    if (to || st != LATENCY || od !== e.d || oe !== e.e) begin
      n_fail++;
      $display("FAIL misalign_wr: timeout=%0d stall=%0d data_out=%h err=%b, required 0/%0d/%h/%b",
               to, st, od, oe, LATENCY, e.d, e.e);
    end
    @(negedge clk);
    n_checks++;
    if (mif.err !== 1'b0 || mif.done !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_err_pulse: err=%b done=%b, required 0/0", mif.err, mif.done);
    end
    issue(1'b0, 16'h0040, 16'h0000, 1'b0, od, oe, st, lat, to);
    e = sb.pop_front();
    n_checks++;
    if (to || od !== e.d || oe !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_rd: timeout=%0d data_out=%h err=%b, required %h/0", to, od, oe, e.d);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_stall_ignored();
    test_back_to_back();
    test_reset_abort();
    test_misalign();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
